vpipe_isa_model: RTL and testbench



---
 rtl/vpipe_isa_pkg.sv | 47 ++++
 rtl/vpipe_isa_alu.sv | 23 ++
 rtl/vpipe_isa_model.sv | 127 ++++++++++++
 tb/tb_vpipe_isa_model.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vpipe_isa_pkg.sv
// Shared types and instruction field helpers for the vpipe ISA reference model.
// Field helpers take the register-index width as an argument so any NREG can reuse them.
package vpipe_isa_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_AND = 2'd3
    } opcode_t;

    // Helpers work on a zero-extended instruction up to this index width.
    localparam int MAX_RI = 8;
    localparam int MAX_IW = 2 + 3 * MAX_RI;

    function automatic logic [MAX_RI-1:0] ri_mask(input int ri);
        logic [MAX_RI-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_RI; i++) begin
            if (i < ri) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [1:0] get_op(input logic [MAX_IW-1:0] inst, input int ri);
        logic [MAX_IW-1:0] sh;
        sh = inst >> (3 * ri);
        return sh[1:0];
    endfunction

    function automatic logic [MAX_RI-1:0] get_rs1(input logic [MAX_IW-1:0] inst, input int ri);
        logic [MAX_IW-1:0] sh;
        sh = inst >> (2 * ri);
        return sh[MAX_RI-1:0] & ri_mask(ri);
    endfunction

    function automatic logic [MAX_RI-1:0] get_rs2(input logic [MAX_IW-1:0] inst, input int ri);
        logic [MAX_IW-1:0] sh;
        sh = inst >> ri;
        return sh[MAX_RI-1:0] & ri_mask(ri);
    endfunction

    function automatic logic [MAX_RI-1:0] get_rd(input logic [MAX_IW-1:0] inst, input int ri);
        return inst[MAX_RI-1:0] & ri_mask(ri);
    endfunction

endpackage

// File: rtl/vpipe_isa_alu.sv
// Combinational ALU for the vpipe ISA model: ADD/SUB wrap modulo 2^DW, NOP yields zero.
module vpipe_isa_alu
    import vpipe_isa_pkg::*;
#(
    parameter int DW = 8
) (
    input  opcode_t         op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/vpipe_isa_model.sv
// ISA-level reference model of the vpipe pipeline: register file, commit port, tracking counter.
// Define VPIPE_ISA_RANDINIT_EN to add a reg_init port that seeds the register file on reset.
module vpipe_isa_model
    import vpipe_isa_pkg::*;
#(
    parameter int         DW       = 8,
    parameter int         NREG     = 4,
    parameter int         RI       = $clog2(NREG),
    parameter int         IW       = 2 + 3 * RI,
    parameter int         CNT_W    = 8,
    parameter logic [1:0] TRACK_OP = 2'd3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 inst_valid,
    input  logic [IW-1:0]        inst,
    output logic                 inst_ready,
    output logic [3:0]           decode,
    output logic                 commit_valid,
    input  logic                 commit_ready,
    output logic [1:0]           commit_op,
    output logic [RI-1:0]        commit_rd,
    output logic [DW-1:0]        commit_data,
    output logic [NREG*DW-1:0]   regs,
    output logic [CNT_W-1:0]     start_cnt
`ifdef VPIPE_ISA_RANDINIT_EN
    ,
    (* keep *) input logic [NREG*DW-1:0] reg_init
`endif
);

    typedef struct packed {
        opcode_t         op;
        logic [RI-1:0]   rd;
        logic [DW-1:0]   data;
    } commit_rec_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_IW-1:0]        inst_ext;
    opcode_t                  op;
    logic [RI-1:0]            rs1;
    logic [RI-1:0]            rs2;
    logic [RI-1:0]            rd;
    logic [MAX_RI-1:0]        rs1_full;
    logic [MAX_RI-1:0]        rs2_full;
    logic [MAX_RI-1:0]        rd_full;

    logic [NREG-1:0][DW-1:0]  rf;
    commit_rec_t              rec;
    logic                     rec_valid;
    logic [CNT_W-1:0]         cnt;
    logic                     accept;
    logic [DW-1:0]            alu_result;
    logic [DW-1:0]            wb_data;

    assign inst_ext = MAX_IW'(inst);
    assign op       = opcode_t'(get_op(inst_ext, RI));
    assign rs1_full = get_rs1(inst_ext, RI);
    assign rs2_full = get_rs2(inst_ext, RI);
    assign rd_full  = get_rd(inst_ext, RI);
    assign rs1      = rs1_full[RI-1:0];
    assign rs2      = rs2_full[RI-1:0];
    assign rd       = rd_full[RI-1:0];

    always_comb begin
        decode     = '0;
        decode[op] = 1'b1;
    end

    // Handshake: an instruction transfers on a cycle where inst_valid && inst_ready;
    // a commit record transfers on a cycle where commit_valid && commit_ready.
    // A taken commit frees the slot in the same cycle, so a new accept can replace it.
    assign inst_ready = start && (!rec_valid || commit_ready);
    assign accept     = inst_valid && inst_ready;

    vpipe_isa_alu #(.DW(DW)) u_alu (
        .op     (op),
        .a      (rf[rs1]),
        .b      (rf[rs2]),
        .result (alu_result)
    );

    assign wb_data = (op == OP_NOP) ? '0 : alu_result;

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef VPIPE_ISA_RANDINIT_EN
            rf <= reg_init;
`else
            rf <= '0;
`endif
            rec       <= '0;
            rec_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (op != OP_NOP) rf[rd] <= alu_result;
                rec       <= '{op: op, rd: rd, data: wb_data};
                rec_valid <= 1'b1;
            end else if (commit_ready) begin
                rec_valid <= 1'b0;
            end
        end
    end

    // Counter only moves on start-high cycles; zero means no tracked instruction seen yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            if (accept && (op == opcode_t'(TRACK_OP))) begin
                cnt <= CNT_W'(1);
            end else if ((cnt != '0) && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign commit_valid = rec_valid;
    assign commit_op    = rec.op;
    assign commit_rd    = rec.rd;
    assign commit_data  = rec.data;
    assign regs         = rf;
    assign start_cnt    = cnt;

endmodule

// File: tb/tb_vpipe_isa_model.sv
// Directed bench for vpipe_isa_model (DW=8, NREG=4) with hand-computed expectations.
// Registers are preloaded by briefly forcing the model's register file.
module tb_vpipe_isa_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        inst_valid;
    logic [7:0]  inst;
    logic        inst_ready;
    logic [3:0]  decode;
    logic        commit_valid;
    logic        commit_ready;
    logic [1:0]  commit_op;
    logic [1:0]  commit_rd;
    logic [7:0]  commit_data;
    logic [31:0] regs;
    logic [7:0]  start_cnt;
`ifdef VPIPE_ISA_RANDINIT_EN
    logic [31:0] reg_init = 32'h0;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'h00;

    always #5 clk = ~clk;

    vpipe_isa_model dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_ready   (inst_ready),
        .decode       (decode),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_op    (commit_op),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .regs         (regs),
        .start_cnt    (start_cnt)
`ifdef VPIPE_ISA_RANDINIT_EN
        ,
        .reg_init     (reg_init)
`endif
    );

    // One clock edge; the bench's own counter model advances alongside.
    task automatic step(input bit tracked);
        if (rst) exp_cnt = 8'h00;
        else if (start) begin
            if (tracked) exp_cnt = 8'h01;
            else if (exp_cnt != 8'h00 && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] val);
        force dut.rf = val;
        step(1'b0);
        release dut.rf;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; inst_valid = 1'b0; inst = 8'h00; commit_ready = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        #1;
        checks++; if (regs !== 32'h0) begin errors++; $display("FAIL reset_regs got %h exp %h", regs, 32'h0); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got %b exp 0", commit_valid); end
        checks++; if (start_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h exp 00", start_cnt); end
        checks++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", inst_ready); end
        checks++; if ({commit_op, commit_rd, commit_data} !== 12'h000) begin errors++; $display("FAIL reset_rec got %h exp 000", {commit_op, commit_rd, commit_data}); end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_dec;
            exp_dec = 4'b0001 << i;
            inst = {i[1:0], 6'b101101};
            #1;
            checks++; if (decode !== exp_dec) begin errors++; $display("FAIL decode_%0d got %b exp %b", i, decode, exp_dec); end
        end
    endtask

    task automatic test_and();
        preload(32'h00003CF0);
        inst = 8'hC6; inst_valid = 1'b1; commit_ready = 1'b1;
        #1;
        checks++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL and_ready got %b exp 1", inst_ready); end
        step(1'b1);
        inst_valid = 1'b0;
        checks++; if (regs !== 32'h00303CF0) begin errors++; $display("FAIL and_regs got %h exp %h", regs, 32'h00303CF0); end
        checks++; if ({commit_valid, commit_op, commit_rd, commit_data} !== {1'b1, 2'd3, 2'd2, 8'h30}) begin errors++; $display("FAIL and_commit got %b %h %h %h exp 1 3 2 30", commit_valid, commit_op, commit_rd, commit_data); end
        checks++; if (start_cnt !== 8'h01) begin errors++; $display("FAIL and_cnt1 got %h exp 01", start_cnt); end
        step(1'b0);
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL and_drain got %b exp 0", commit_valid); end
        checks++; if (start_cnt !== 8'h02) begin errors++; $display("FAIL and_cnt2 got %h exp 02", start_cnt); end
        step(1'b0);
        checks++; if (start_cnt !== 8'h03) begin errors++; $display("FAIL and_cnt3 got %h exp 03", start_cnt); end
    endtask

    task automatic test_sub_wrap();
        preload(32'h00000201);
        inst = 8'h84; inst_valid = 1'b1; commit_ready = 1'b1;
        step(1'b0);
        inst_valid = 1'b0;
        checks++; if (regs !== 32'h000002FF) begin errors++; $display("FAIL sub_regs got %h exp %h", regs, 32'h000002FF); end
        checks++; if ({commit_valid, commit_op, commit_rd, commit_data} !== {1'b1, 2'd2, 2'd0, 8'hFF}) begin errors++; $display("FAIL sub_commit got %b %h %h %h exp 1 2 0 ff", commit_valid, commit_op, commit_rd, commit_data); end
        checks++; if (start_cnt !== exp_cnt) begin errors++; $display("FAIL sub_cnt got %h exp %h", start_cnt, exp_cnt); end
        step(1'b0);
    endtask

    task automatic test_backpressure();
        preload(32'h00221000);
        inst = 8'h5B; inst_valid = 1'b1; commit_ready = 1'b0;
        step(1'b0);
        checks++; if (regs !== 32'h32221000) begin errors++; $display("FAIL bp_add_regs got %h exp %h", regs, 32'h32221000); end
        inst = 8'hC6;
        for (int i = 0; i < 5; i++) begin
            checks++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d got %b exp 0", i, inst_ready); end
            step(1'b0);
            checks++; if (regs !== 32'h32221000) begin errors++; $display("FAIL bp_regs_%0d got %h exp %h", i, regs, 32'h32221000); end
            checks++; if ({commit_valid, commit_data} !== {1'b1, 8'h32}) begin errors++; $display("FAIL bp_hold_%0d got %b %h exp 1 32", i, commit_valid, commit_data); end
        end
        commit_ready = 1'b1;
        #1;
        checks++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", inst_ready); end
        step(1'b1);
        inst_valid = 1'b0;
        checks++; if (regs !== 32'h32001000) begin errors++; $display("FAIL bp_next_regs got %h exp %h", regs, 32'h32001000); end
        checks++; if ({commit_valid, commit_op, commit_rd, commit_data} !== {1'b1, 2'd3, 2'd2, 8'h00}) begin errors++; $display("FAIL bp_next_commit got %b %h %h %h exp 1 3 2 00", commit_valid, commit_op, commit_rd, commit_data); end
        checks++; if (start_cnt !== 8'h01) begin errors++; $display("FAIL bp_cnt got %h exp 01", start_cnt); end
        step(1'b0);
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", commit_valid); end
    endtask

    task automatic test_reset_mid_stall();
        inst = 8'h5B; inst_valid = 1'b1; commit_ready = 1'b0;
        step(1'b0);
        inst_valid = 1'b0;
        checks++; if ({commit_valid, commit_data} !== {1'b1, 8'h10}) begin errors++; $display("FAIL rms_pending got %b %h exp 1 10", commit_valid, commit_data); end
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rms_cv got %b exp 0", commit_valid); end
        checks++; if (regs !== 32'h0) begin errors++; $display("FAIL rms_regs got %h exp 0", regs); end
        checks++; if (start_cnt !== 8'h00) begin errors++; $display("FAIL rms_cnt got %h exp 00", start_cnt); end
        checks++; if ({commit_op, commit_rd, commit_data} !== 12'h000) begin errors++; $display("FAIL rms_rec got %h exp 000", {commit_op, commit_rd, commit_data}); end
    endtask

    task automatic test_start_low();
        preload(32'h04030201);
        inst = 8'hC6; inst_valid = 1'b1; commit_ready = 1'b0;
        step(1'b1);
        checks++; if (regs !== 32'h04000201) begin errors++; $display("FAIL sl_and_regs got %h exp %h", regs, 32'h04000201); end
        start = 1'b0; inst = 8'h5B;
        #1;
        checks++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL sl_ready got %b exp 0", inst_ready); end
        repeat (3) step(1'b0);
        checks++; if (regs !== 32'h04000201) begin errors++; $display("FAIL sl_regs got %h exp %h", regs, 32'h04000201); end
        checks++; if (start_cnt !== 8'h01) begin errors++; $display("FAIL sl_cnt got %h exp 01", start_cnt); end
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL sl_hold got %b exp 1", commit_valid); end
        commit_ready = 1'b1;
        #1;
        checks++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL sl_ready_cr got %b exp 0", inst_ready); end
        step(1'b0);
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL sl_drain got %b exp 0", commit_valid); end
        checks++; if ({regs, start_cnt} !== {32'h04000201, 8'h01}) begin errors++; $display("FAIL sl_frozen got %h %h exp 04000201 01", regs, start_cnt); end
        inst_valid = 1'b0; start = 1'b1;
    endtask

    task automatic test_saturation();
        inst = 8'hC6; inst_valid = 1'b1; commit_ready = 1'b1;
        step(1'b1);
        inst_valid = 1'b0;
        checks++; if (start_cnt !== 8'h01) begin errors++; $display("FAIL sat_start got %h exp 01", start_cnt); end
        repeat (253) step(1'b0);
        checks++; if (start_cnt !== 8'hFE) begin errors++; $display("FAIL sat_fe got %h exp fe", start_cnt); end
        step(1'b0);
        checks++; if (start_cnt !== 8'hFF) begin errors++; $display("FAIL sat_ff got %h exp ff", start_cnt); end
        step(1'b0);
        checks++; if (start_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold got %h exp ff", start_cnt); end
    endtask

`ifdef VPIPE_ISA_RANDINIT_EN
    task automatic test_randinit();
        reg_init = 32'h04030201;
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        checks++; if (regs !== 32'h04030201) begin errors++; $display("FAIL ri_regs got %h exp 04030201", regs); end
        checks++; if ({commit_valid, start_cnt} !== 9'h000) begin errors++; $display("FAIL ri_state got %b %h exp 0 00", commit_valid, start_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_and();
        test_sub_wrap();
        test_backpressure();
        test_reset_mid_stall();
        test_start_low();
        test_saturation();
`ifdef VPIPE_ISA_RANDINIT_EN
        test_randinit();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
